// File: rtl/sht40_i2c_target.sv
// I2C target emulating an SHT40: ACKs command writes and serves the 6-byte T/RH frame with CRC-8 on reads.
// SDA is open-drain: the block only ever pulls low or releases.
module sht40_i2c_target #(
    parameter logic [6:0]  DEVICE_ADDR = 7'h44,
    parameter logic [7:0]  CRC_INIT    = 8'hFF,
    parameter int unsigned READ_BYTES  = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Scl_In,
    input  logic        Sda_In,
    output logic        Sda_Pull_Low,
    input  logic [15:0] Temp_Word,
    input  logic [15:0] Rh_Word,
    output logic [7:0]  Cmd_Byte,
    output logic        Cmd_Valid,
    output logic        Busy,
    output logic [3:0]  Bytes_Sent
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;
    localparam logic [CNT_W-1:0] BITS_PER_BYTE = CNT_W'(8);
    localparam logic [CNT_W-1:0] CNT_MAX       = '1;
    localparam logic [CNT_W-1:0] FRAME_LEN     = CNT_W'(READ_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_IGNORE, S_ADDR_ACK, S_WR_RX, S_WR_ACK, S_TX, S_TX_ACK
    } state_t;

    // CRC-8, poly 0x31, MSB first over both bytes of the word, no reflection or final XOR
    function automatic logic [BYTE_W-1:0] crc8(input logic [WORD_W-1:0] data);
        logic [BYTE_W-1:0] c;
        c = CRC_INIT;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (c[BYTE_W-1] ^ data[i]) c = {c[BYTE_W-2:0], 1'b0} ^ 8'h31;
            else                       c = {c[BYTE_W-2:0], 1'b0};
        end
        return c;
    endfunction

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_hist_q, sda_hist_q;
    logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]   shift_q, shift_d;
    logic                rw_q, rw_d;
    logic [BYTE_W-1:0]   tx_shift_q, tx_shift_d;
    logic [CNT_W-1:0]    byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0]    bytes_sent_q, bytes_sent_d;
    logic [WORD_W-1:0]   temp_q, temp_d, rh_q, rh_d;
    logic [BYTE_W-1:0]   crc_t_q, crc_t_d, crc_rh_q, crc_rh_d;
    logic                pull_q, pull_d;
    logic [BYTE_W-1:0]   cmd_byte_q, cmd_byte_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic                busy_q, busy_d;
    logic [BYTE_W-1:0]   rx_shift_c, next_byte_c;

    // Two-flop synchronisers plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], Scl_In};
            sda_sync_q <= {sda_sync_q[0], Sda_In};
            scl_hist_q <= scl_sync_q[1];
            sda_hist_q <= sda_sync_q[1];
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    assign start_det = scl_s & sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & ~sda_hist_q & sda_s;

    // Frame byte selected by the index of the next byte to transmit
    always_comb begin
        next_byte_c = 8'hFF;
        if (byte_idx_q < FRAME_LEN) begin
            unique case (byte_idx_q)
                CNT_W'(0): next_byte_c = temp_q[15:8];
                CNT_W'(1): next_byte_c = temp_q[7:0];
                CNT_W'(2): next_byte_c = crc_t_q;
                CNT_W'(3): next_byte_c = rh_q[15:8];
                CNT_W'(4): next_byte_c = rh_q[7:0];
                CNT_W'(5): next_byte_c = crc_rh_q;
                default:   next_byte_c = 8'hFF;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rw_d         = rw_q;
        tx_shift_d   = tx_shift_q;
        byte_idx_d   = byte_idx_q;
        bytes_sent_d = bytes_sent_q;
        temp_d       = temp_q;
        rh_d         = rh_q;
        crc_t_d      = crc_t_q;
        crc_rh_d     = crc_rh_q;
        pull_d       = pull_q;
        cmd_byte_d   = cmd_byte_q;
        cmd_valid_d  = 1'b0;
        busy_d       = busy_q;
        rx_shift_c   = {shift_q[BYTE_W-2:0], sda_s};

        if (start_det) begin
            state_d   = S_ADDR;
            bit_cnt_d = '0;
            pull_d    = 1'b0;
        end else if (stop_det) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            pull_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_IGNORE: pull_d = 1'b0;
                S_ADDR: begin
                    if (scl_rise && bit_cnt_q != BITS_PER_BYTE) begin
                        shift_d   = rx_shift_c;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else if (scl_fall && bit_cnt_q == BITS_PER_BYTE) begin
                        if (shift_q[BYTE_W-1:1] == DEVICE_ADDR) begin
                            pull_d  = 1'b1;
                            busy_d  = 1'b1;
                            rw_d    = shift_q[0];
                            state_d = S_ADDR_ACK;
                        end else begin
                            pull_d  = 1'b0;
                            busy_d  = 1'b0;
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (!rw_q) begin
                            pull_d  = 1'b0;
                            state_d = S_WR_RX;
                        end else begin
                            // Snapshot both words so the frame stays coherent for the whole read
                            temp_d       = Temp_Word;
                            rh_d         = Rh_Word;
                            crc_t_d      = crc8(Temp_Word);
                            crc_rh_d     = crc8(Rh_Word);
                            pull_d       = ~Temp_Word[15];
                            tx_shift_d   = {Temp_Word[14:8], 1'b1};
                            bit_cnt_d    = CNT_W'(1);
                            byte_idx_d   = CNT_W'(1);
                            bytes_sent_d = '0;
                            state_d      = S_TX;
                        end
                    end
                end
                S_WR_RX: begin
                    if (scl_rise && bit_cnt_q != BITS_PER_BYTE) begin
                        shift_d   = rx_shift_c;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == BITS_PER_BYTE - CNT_W'(1)) begin
                            cmd_byte_d  = rx_shift_c;
                            cmd_valid_d = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == BITS_PER_BYTE) begin
                        pull_d  = 1'b1;
                        state_d = S_WR_ACK;
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        pull_d    = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = S_WR_RX;
                    end
                end
                S_TX: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == BITS_PER_BYTE) begin
                            pull_d  = 1'b0;
                            state_d = S_TX_ACK;
                            if (bytes_sent_q != CNT_MAX) bytes_sent_d = bytes_sent_q + CNT_W'(1);
                        end else begin
                            pull_d     = ~tx_shift_q[BYTE_W-1];
                            tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b1};
                            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_TX_ACK: begin
                    if (scl_rise && sda_s) begin
                        busy_d  = 1'b0;
                        state_d = S_IGNORE;
                    end else if (scl_fall) begin
                        pull_d     = ~next_byte_c[BYTE_W-1];
                        tx_shift_d = {next_byte_c[BYTE_W-2:0], 1'b1};
                        bit_cnt_d  = CNT_W'(1);
                        if (byte_idx_q != CNT_MAX) byte_idx_d = byte_idx_q + CNT_W'(1);
                        state_d    = S_TX;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rw_q         <= 1'b0;
            tx_shift_q   <= '1;
            byte_idx_q   <= '0;
            bytes_sent_q <= '0;
            temp_q       <= '0;
            rh_q         <= '0;
            crc_t_q      <= '0;
            crc_rh_q     <= '0;
            pull_q       <= 1'b0;
            cmd_byte_q   <= '0;
            cmd_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rw_q         <= rw_d;
            tx_shift_q   <= tx_shift_d;
            byte_idx_q   <= byte_idx_d;
            bytes_sent_q <= bytes_sent_d;
            temp_q       <= temp_d;
            rh_q         <= rh_d;
            crc_t_q      <= crc_t_d;
            crc_rh_q     <= crc_rh_d;
            pull_q       <= pull_d;
            cmd_byte_q   <= cmd_byte_d;
            cmd_valid_q  <= cmd_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign Sda_Pull_Low = pull_q;
    assign Cmd_Byte     = cmd_byte_q;
    assign Cmd_Valid    = cmd_valid_q;
    assign Busy         = busy_q;
    assign Bytes_Sent   = bytes_sent_q;

endmodule

// File: doc/sht40_i2c_target.md
Name: sht40_i2c_target

Overview:
I2C target (responder) that emulates an SHT40 sensor on the bus driven by the team's I2C master.
- Detects START/STOP and matches the 7-bit device address.
- Receives command bytes on writes and ACKs them.
- On reads, returns the 6-byte SHT40 frame: T_MSB, T_LSB, CRC(T), RH_MSB, RH_LSB, CRC(RH).
- Used as the bench/FPGA stand-in for the real sensor. Open-drain SDA only: the block pulls low or releases.

Parameters:
DEVICE_ADDR, 7'h44, 7-bit address the block responds to.
CRC_INIT, 8'hFF, CRC-8 seed (polynomial fixed at 0x31, no reflection, no final XOR).
READ_BYTES, 6, frame bytes returned per read before the block releases SDA permanently.

Ports:
clk  in  1  system clock; all logic on posedge.
rst_n  in  1  reset, synchronous, active-low.
Scl_In  in  1  bus SCL (asynchronous to clk).
Sda_In  in  1  bus SDA as seen on the wire (asynchronous to clk).
Sda_Pull_Low  out  1  1 = drive SDA to 0; 0 = release (Z, pulled high externally).
Temp_Word  in  16  raw temperature; sampled at read-address ACK.
Rh_Word  in  16  raw humidity; sampled at read-address ACK.
Cmd_Byte  out  8  last byte received in a write transfer.
Cmd_Valid  out  1  one-cycle pulse when Cmd_Byte updates.
Busy  out  1  1 from an address match until STOP, NACK or mismatch.
Bytes_Sent  out  4  frame bytes transmitted in the current read; saturates at 15.

Behaviour:
Reset:
- When rst_n=0 at posedge: Sda_Pull_Low=0, Cmd_Byte=0, Cmd_Valid=0, Busy=0, Bytes_Sent=0, state=IDLE, synchronisers loaded with 1.
- Reset mid-transfer releases SDA immediately.
Input conditioning:
- Scl_In and Sda_In each pass through a 2-flop synchroniser, plus one history flop for edge detect. Input-to-internal latency is 2 clk.
- SCL rise/fall = synced SCL 0->1 / 1->0.
- START = synced SDA falls while synced SCL=1. STOP = synced SDA rises while synced SCL=1.
- START/STOP take priority over all states. STOP -> IDLE. START (including repeated start) -> ADDR with the bit counter cleared.
Bit timing:
- Received bits are sampled on SCL rise.
- Sda_Pull_Low changes only on the clk after an SCL fall, never while SCL=1.
States:
- IDLE: SDA released, Busy=0. Waits for START.
- ADDR: shift in 8 bits MSB first (7 address bits + R/W).
  - After the 8th rise, on the next SCL fall: if the address equals DEVICE_ADDR, pull low (ACK), set Busy=1 and go to ADDR_ACK.
  - Otherwise release and go to IGNORE.
- IGNORE: SDA released; waits for START/STOP only.
- ADDR_ACK: hold SDA low through the 9th clock. On its fall:
  - R/W=0: release and go to WR_RX.
  - R/W=1: latch Temp_Word/Rh_Word, compute both CRCs, load byte 0, drive its bit7 (pull low iff bit=0), Bytes_Sent=0, go to TX.
- WR_RX: shift in 8 bits. After the 8th rise:
  - Cmd_Byte updates and Cmd_Valid pulses for exactly 1 clk.
  - On the next fall pull low (ACK), go to WR_ACK.
- WR_ACK: on the 9th fall release and return to WR_RX. Unlimited write bytes are accepted.
- TX: on each SCL fall present the next bit. After the 8th bit's fall, release and go to TX_ACK; Bytes_Sent increments at that fall.
- TX_ACK: sample SDA on the 9th rise.
  - 1 (NACK): Busy=0, go to IGNORE.
  - 0 (ACK), on the 9th fall: load the next frame byte and go to TX. Once READ_BYTES bytes are sent, later bytes read as 8'hFF (SDA released).
CRC:
- CRC-8 over MSB then LSB of each 16-bit word; polynomial 0x31, seed CRC_INIT.
- Computed within the latch cycle, combinationally or by an unrolled function.
- Required vector: 0xBEEF -> 0x92.
Simultaneous events:
- START and STOP cannot coincide. A START seen in the same clk as an SCL edge wins.
- Cmd_Valid is not asserted for a byte aborted by START/STOP before its 8th rise.

Test Plan:
- Write 0x88, then byte 0xFD (ACK on both 9th clocks) -> Sda_Pull_Low=1 during both ACK slots; Cmd_Byte=0xFD; single 1-clk Cmd_Valid; Busy=1 until STOP, then 0.
- Read 0x89, Temp_Word=0xBEEF, Rh_Word=0x1234, master ACKs 5 bytes and NACKs the 6th -> bus bytes BE EF 92 12 34 37; Bytes_Sent=6; Busy=0 after the NACK.
- Address 0x45 write -> no ACK (SDA high on 9th rise); Busy stays 0; Cmd_Valid never pulses; block responds normally to the next START with 0x44.
- Write cmd 0xFD, repeated START, read 0x89 -> ACK on the repeated address; first read byte = Temp_Word[15:8]; no STOP required between.
- Read 8 bytes, all ACKed -> bytes 7 and 8 = 0xFF; Bytes_Sent=8; Sda_Pull_Low never changes while SCL=1 across the whole run (assertion).
- Reset (rst_n=0 for 1 clk) during bit 3 of read byte 1 -> Sda_Pull_Low=0 and Busy=0 next clk; the block ignores the rest of the byte and ACKs the next START+0x89.
